// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: data-bus request/response, access size
// and the ex_mem / mem_wb pipeline records.
package mem_access_pkg;

    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;
    typedef logic [31:0] inst_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic    valid;
        word_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic      valid;
        inst_t     inst;
        word_t     inst_pc;
        word_t     alu_result;
        word_t     store_data;
        reg_addr_t reg_dest_addr;
        logic      reg_write_enable;
        logic      mem_read;
        logic      mem_write;
        logic [2:0] mem_funct3;
    } ex_mem_t;

    typedef struct packed {
        logic      valid;
        inst_t     inst;
        word_t     inst_pc;
        word_t     reg_write_data;
        reg_addr_t reg_dest_addr;
        logic      reg_write_enable;
    } mem_wb_t;

    function automatic strobe_t size_mask(input msize_t size);
        case (size)
            MSIZE1:  return 8'h01;
            MSIZE2:  return 8'h03;
            MSIZE4:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic mem_wb_t to_mem_wb(input ex_mem_t rec, input word_t data, input logic we);
        mem_wb_t wb;
        wb.valid            = 1'b1;
        wb.inst             = rec.inst;
        wb.inst_pc          = rec.inst_pc;
        wb.reg_write_data   = data;
        wb.reg_dest_addr    = rec.reg_dest_addr;
        wb.reg_write_enable = we;
        return wb;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus interface between the memory stage (master) and the memory system (slave).
interface mem_access_if;
    mem_access_pkg::dbus_req_t  dreq;
    mem_access_pkg::dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/mem_access_align.sv
// Combinational byte-lane logic: store strobe/data placement, load extract and
// extend, and natural-alignment check.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0] offset,
    input  logic [2:0] funct3,
    input  word_t      store_data,
    input  word_t      load_raw,
    output msize_t     size,
    output strobe_t    strobe,
    output word_t      wdata,
    output word_t      load_data,
    output logic       aligned
);
    word_t shifted;

    always_comb begin
        size      = msize_t'(funct3[1:0]);
        strobe    = size_mask(size) << offset;
        wdata     = store_data << {offset, 3'b000};
        shifted   = load_raw >> {offset, 3'b000};
        load_data = '0;
        aligned   = 1'b1;
        // funct3[2] selects zero-extension for sub-doubleword loads
        case (size)
            MSIZE1: begin
                load_data = {{56{shifted[7] & ~funct3[2]}}, shifted[7:0]};
            end
            MSIZE2: begin
                load_data = {{48{shifted[15] & ~funct3[2]}}, shifted[15:0]};
                aligned   = (offset[0] == 1'b0);
            end
            MSIZE4: begin
                load_data = {{32{shifted[31] & ~funct3[2]}}, shifted[31:0]};
                aligned   = (offset[1:0] == 2'b00);
            end
            default: begin
                load_data = shifted;
                aligned   = (offset == 3'b000);
            end
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores on the data bus, stalls EX while a
// transaction is outstanding and registers the mem_wb record.
module mem_access
    import mem_access_pkg::*;
#(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  ex_mem_t             ex_mem_state,
    output mem_wb_t             mem_wb_state,
    mem_access_if.master        dbus,
    output logic                misalign,
    output logic                ok
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t  state, state_nx;
    ex_mem_t pend, pend_nx, sel;
    mem_wb_t wb_nx;
    logic    misalign_nx;
    logic    is_mem;
    msize_t  al_size;
    strobe_t al_strobe;
    word_t   al_wdata, al_load;
    logic    al_aligned;
    logic    unused_addr_ok;

    assign unused_addr_ok = dbus.dresp.addr_ok;

    // While BUSY the aligner sees only the pending record, so dreq stays stable
    assign sel    = (state == BUSY) ? pend : ex_mem_state;
    assign is_mem = ex_mem_state.mem_read | ex_mem_state.mem_write;

    mem_align u_align (
        .offset     (sel.alu_result[2:0]),
        .funct3     (sel.mem_funct3),
        .store_data (sel.store_data),
        .load_raw   (dbus.dresp.data),
        .size       (al_size),
        .strobe     (al_strobe),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .aligned    (al_aligned)
    );

    always_comb begin
        state_nx    = state;
        pend_nx     = pend;
        wb_nx       = '0;
        misalign_nx = 1'b0;
        ok          = (state == IDLE);
        dbus.dreq   = '0;
        case (state)
            IDLE: begin
                if (ex_mem_state.valid) begin
                    if (!is_mem) begin
                        wb_nx = to_mem_wb(ex_mem_state, ex_mem_state.alu_result,
                                          ex_mem_state.reg_write_enable);
                    end else if (MISALIGN_CHECK && !al_aligned) begin
                        wb_nx       = to_mem_wb(ex_mem_state, ex_mem_state.alu_result, 1'b0);
                        misalign_nx = 1'b1;
                    end else begin
                        pend_nx  = ex_mem_state;
                        state_nx = BUSY;
                    end
                end
            end
            default: begin
                dbus.dreq.valid  = 1'b1;
                dbus.dreq.addr   = pend.alu_result;
                dbus.dreq.size   = al_size;
                dbus.dreq.strobe = pend.mem_write ? al_strobe : '0;
                dbus.dreq.data   = pend.mem_write ? al_wdata : '0;
                if (dbus.dresp.data_ok) begin
                    wb_nx = pend.mem_write ? to_mem_wb(pend, '0, 1'b0)
                                           : to_mem_wb(pend, al_load, pend.reg_write_enable);
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pend         <= '0;
            mem_wb_state <= '0;
            misalign     <= 1'b0;
        end else begin
            state        <= state_nx;
            pend         <= pend_nx;
            mem_wb_state <= wb_nx;
            misalign     <= misalign_nx;
        end
    end
endmodule
